// File: rtl/crc_stream_engine.sv
// Streaming CRC engine. Configuration loads in one parallel transaction, data
// and results use valid/ready handshakes, and BPC message bits fold per clock.
module crc_stream_engine #(
  parameter int unsigned MAX_WIDTH = 32,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BPC       = 1,
  parameter int unsigned WB        = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WB-1:0]        cfg_width,
  input  logic [MAX_WIDTH-1:0] cfg_poly,
  input  logic [MAX_WIDTH-1:0] cfg_init,
  input  logic [MAX_WIDTH-1:0] cfg_xor,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_crc,
  output logic                 busy
);

  localparam int unsigned           STEPS    = DATA_W / BPC;
  localparam int unsigned           CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(STEPS - 1);
  localparam logic [MAX_WIDTH-1:0]  RST_POLY = MAX_WIDTH'(64'h0000_0000_04C1_1DB7);
  localparam logic [WB-1:0]         WMAX     = WB'(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]      stream_q, stream_d;
  logic                   last_q, last_d;
  logic                   msg_q, msg_d;
  logic [MAX_WIDTH-1:0]   r_q, r_d;
  logic [MAX_WIDTH-1:0]   out_crc_q, out_crc_d;
  logic [WB-1:0]          width_q, width_d;
  logic [MAX_WIDTH-1:0]   mask_q, mask_d;
  logic [MAX_WIDTH-1:0]   poly_q, poly_d;
  logic [MAX_WIDTH-1:0]   init_q, init_d;
  logic [MAX_WIDTH-1:0]   xor_q, xor_d;
  logic                   refin_q, refin_d;
  logic                   refout_q, refout_d;
  logic                   cfg_fire;
  logic [MAX_WIDTH-1:0]   r_fold;

  function automatic logic [WB-1:0] sat_width(input logic [WB-1:0] w);
    if (w == '0 || 32'(w) > MAX_WIDTH) return WMAX;
    return w;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] width_mask(input logic [WB-1:0] w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) m[i] = (i < 32'(w));
    return m;
  endfunction

  // Reorders a beat so that stream bit 0 is the first message bit to fold.
  function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] d,
                                                   input logic              refin);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < DATA_W / 8; k++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        s[8*k+j] = refin ? d[8*k+j] : d[8*k+7-j];
      end
    end
    return s;
  endfunction

  // The feedback tap is the top bit of the active width, isolated from the mask.
  function automatic logic [MAX_WIDTH-1:0] fold(input logic [MAX_WIDTH-1:0] r,
                                                input logic [BPC-1:0]       bits,
                                                input logic [MAX_WIDTH-1:0] mask,
                                                input logic [MAX_WIDTH-1:0] poly);
    logic [MAX_WIDTH-1:0] top;
    logic [MAX_WIDTH-1:0] acc;
    logic                 fb;
    top = mask & ~(mask >> 1);
    acc = r;
    for (int unsigned i = 0; i < BPC; i++) begin
      fb  = ((acc & top) != '0) ^ bits[i];
      acc = (acc << 1) & mask;
      if (fb) acc = acc ^ poly;
    end
    return acc;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] crc_result(input logic [MAX_WIDTH-1:0] r,
                                                      input logic [WB-1:0]        w,
                                                      input logic [MAX_WIDTH-1:0] mask,
                                                      input logic [MAX_WIDTH-1:0] xr,
                                                      input logic                 refout);
    logic [MAX_WIDTH-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) rev[i] = r[MAX_WIDTH-1-i];
    rev = rev >> (MAX_WIDTH - 32'(w));
    return ((refout ? rev : r) ^ xr) & mask;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stream_q  <= '0;
      last_q    <= 1'b0;
      msg_q     <= 1'b0;
      r_q       <= '1;
      out_crc_q <= '0;
      width_q   <= WMAX;
      mask_q    <= '1;
      poly_q    <= RST_POLY;
      init_q    <= '1;
      xor_q     <= '1;
      refin_q   <= 1'b1;
      refout_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stream_q  <= stream_d;
      last_q    <= last_d;
      msg_q     <= msg_d;
      r_q       <= r_d;
      out_crc_q <= out_crc_d;
      width_q   <= width_d;
      mask_q    <= mask_d;
      poly_q    <= poly_d;
      init_q    <= init_d;
      xor_q     <= xor_d;
      refin_q   <= refin_d;
      refout_q  <= refout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stream_d  = stream_q;
    last_d    = last_q;
    msg_d     = msg_q;
    r_d       = r_q;
    out_crc_d = out_crc_q;
    width_d   = width_q;
    mask_d    = mask_q;
    poly_d    = poly_q;
    init_d    = init_q;
    xor_d     = xor_q;
    refin_d   = refin_q;
    refout_d  = refout_q;

    in_ready  = (state_q == S_IDLE);
    cfg_ready = (state_q == S_IDLE) && !msg_q;
    busy      = (state_q != S_IDLE) || msg_q;
    out_valid = (state_q == S_DONE);
    cfg_fire  = cfg_valid && cfg_ready;
    r_fold    = fold(r_q, stream_q[BPC-1:0], mask_q, poly_q);

    unique case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          width_d  = sat_width(cfg_width);
          mask_d   = width_mask(width_d);
          poly_d   = cfg_poly & mask_d;
          init_d   = cfg_init & mask_d;
          xor_d    = cfg_xor & mask_d;
          refin_d  = cfg_refin;
          refout_d = cfg_refout;
          r_d      = cfg_init & mask_d;
        end
        // A beat accepted alongside a config uses the new reflection setting.
        if (in_valid) begin
          stream_d = order_bits(in_data, refin_d);
          last_d   = in_last || flush;
          msg_d    = 1'b1;
          cnt_d    = CNT_LAST;
          state_d  = S_SHIFT;
        end else if (flush) begin
          out_crc_d = crc_result(r_q, width_q, mask_q, xor_q, refout_q);
          state_d   = S_DONE;
        end
      end
      S_SHIFT: begin
        r_d      = r_fold;
        stream_d = stream_q >> BPC;
        if (cnt_q == '0) begin
          if (last_q) begin
            out_crc_d = crc_result(r_fold, width_q, mask_q, xor_q, refout_q);
            state_d   = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          r_d       = init_q;
          msg_d     = 1'b0;
          out_crc_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_crc = out_crc_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed and table-driven bench for crc_stream_engine: an 8-bit/1-bpc instance
// (u0) and a 32-bit/8-bpc instance (u1), checked against catalogue CRCs and a serial model.
module tb_crc_stream_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_bad = 0;
  logic mon_en = 1'b0;

  logic        cfg_valid = 1'b0, cfg_ready;
  logic [5:0]  cfg_width = '0;
  logic [31:0] cfg_poly = '0, cfg_init = '0, cfg_xor = '0;
  logic        cfg_refin = 1'b0, cfg_refout = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0, flush = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_ready = 1'b0, busy;
  logic [31:0] out_crc;

  logic        v_cfg_valid = 1'b0, v_cfg_ready;
  logic        v_in_valid = 1'b0, v_in_ready, v_in_last = 1'b0, v_flush = 1'b0;
  logic [31:0] v_in_data = '0;
  logic        v_out_valid, v_out_ready = 1'b0, v_busy;
  logic [31:0] v_out_crc;

  crc_stream_engine #(.MAX_WIDTH(32), .DATA_W(8), .BPC(1)) u0 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_width(cfg_width),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xor(cfg_xor),
    .cfg_refin(cfg_refin), .cfg_refout(cfg_refout),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_crc(out_crc),
    .busy(busy)
  );

  crc_stream_engine #(.MAX_WIDTH(32), .DATA_W(32), .BPC(8)) u1 (
    .clk(clk), .rst(rst),
    .cfg_valid(v_cfg_valid), .cfg_ready(v_cfg_ready), .cfg_width(cfg_width),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xor(cfg_xor),
    .cfg_refin(cfg_refin), .cfg_refout(cfg_refout),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_data(v_in_data), .in_last(v_in_last),
    .flush(v_flush), .out_valid(v_out_valid), .out_ready(v_out_ready), .out_crc(v_out_crc),
    .busy(v_busy)
  );

  typedef struct {
    logic [5:0]  w;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xr;
    bit          rin;
    bit          rout;
    logic [31:0] exp;
  } vec_t;

  logic [7:0] msg [64];
  int         mlen = 0;

  // u1 may accept a config only once its result has been consumed.
  always @(posedge clk) begin
    #2;
    if (mon_en && v_cfg_valid && v_cfg_ready) stall_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [31:0] ref_crc(input int w_in, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xr,
                                          input bit rin, input bit rout,
                                          input logic [7:0] m [64], input int len);
    int          w;
    logic [31:0] mask, r, res;
    logic        b, fb;
    w    = (w_in == 0 || w_in > 32) ? 32 : w_in;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r    = init & mask;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < 8; j++) begin
        b  = rin ? m[k][j] : m[k][7-j];
        fb = r[w-1] ^ b;
        r  = (r << 1) & mask;
        if (fb) r = r ^ (poly & mask);
      end
    end
    res = r;
    if (rout) begin
      res = '0;
      for (int i = 0; i < w; i++) res[i] = r[w-1-i];
    end
    return (res ^ xr) & mask;
  endfunction

  task automatic load_str(input string s);
    for (int k = 0; k < s.len(); k++) msg[k] = s[k];
    mlen = s.len();
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_cfg(input vec_t v);
    int t = 0;
    cfg_valid = 1'b1; cfg_width = v.w; cfg_poly = v.poly; cfg_init = v.init;
    cfg_xor = v.xr; cfg_refin = v.rin; cfg_refout = v.rout;
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    if (!cfg_ready) to_fail("cfg_accept");
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [31:0] d, input bit last, input bit fl);
    int t = 0;
    if (sel) begin v_in_valid = 1'b1; v_in_data = d; v_in_last = last; v_flush = fl; end
    else begin in_valid = 1'b1; in_data = d[7:0]; in_last = last; flush = fl; end
    while (!(sel ? v_in_ready : in_ready) && t < 200) begin @(negedge clk); t++; end
    if (!(sel ? v_in_ready : in_ready)) to_fail("beat_accept");
    @(negedge clk);
    v_in_valid = 1'b0; v_in_last = 1'b0; v_flush = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    int t = 0;
    flush = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) to_fail("flush_accept");
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic send_msg(input bit sel, input int gmax, input bit end_flush);
    if (sel) begin
      for (int b = 0; b < mlen / 4; b++) begin
        repeat ($urandom_range(0, gmax)) @(negedge clk);
        send(1'b1, {msg[4*b+3], msg[4*b+2], msg[4*b+1], msg[4*b]}, b == mlen / 4 - 1, 1'b0);
      end
    end else begin
      for (int k = 0; k < mlen; k++) begin
        repeat ($urandom_range(0, gmax)) @(negedge clk);
        send(1'b0, {24'd0, msg[k]}, (k == mlen - 1) && !end_flush, 1'b0);
      end
      if (end_flush) begin
        repeat ($urandom_range(0, gmax)) @(negedge clk);
        do_flush();
      end
    end
  endtask

  task automatic get_result(input bit sel, input logic [31:0] exp, input int exp_lat,
                            input int rdy_gap, input string name);
    int n = 1;
    while (!(sel ? v_out_valid : out_valid) && n < 300) begin @(negedge clk); n++; end
    if (!(sel ? v_out_valid : out_valid)) begin
      to_fail(name);
    end else begin
      chk(name, 64'(sel ? v_out_crc : out_crc), 64'(exp));
      if (exp_lat > 0) chk({name, "_latency"}, 64'(n), 64'(exp_lat));
      repeat (rdy_gap) @(negedge clk);
      mon_en = 1'b0;
      if (sel) v_out_ready = 1'b1; else out_ready = 1'b1;
      @(negedge clk);
      v_out_ready = 1'b0; out_ready = 1'b0;
      chk({name, "_after_handshake"},
          64'(sel ? {v_out_valid, v_in_ready} : {out_valid, in_ready}), 64'(2'b01));
    end
  endtask

  initial begin
    vec_t        tbl [11];
    vec_t        crc32;
    vec_t        rv;
    int          bad;
    logic [31:0] e;

    crc32 = '{6'd32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hCBF43926};
    tbl[0]  = '{6'd16, 32'h00001021, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 32'h000029B1};
    tbl[1]  = '{6'd8,  32'h00000007, 32'h0,        32'h0, 1'b0, 1'b0, 32'h000000F4};
    tbl[2]  = '{6'd32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFC891918};
    tbl[3]  = '{6'd32, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'h0376E6E7};
    tbl[4]  = '{6'd16, 32'h00008005, 32'h0,        32'h0, 1'b1, 1'b1, 32'h0000BB3D};
    tbl[5]  = '{6'd16, 32'h00008005, 32'h0000FFFF, 32'h0, 1'b1, 1'b1, 32'h00004B37};
    tbl[6]  = '{6'd16, 32'h00001021, 32'h0,        32'h0, 1'b1, 1'b1, 32'h00002189};
    tbl[7]  = '{6'd5,  32'h00000005, 32'h0000001F, 32'h1F, 1'b1, 1'b1, 32'h00000019};
    tbl[8]  = '{6'd7,  32'h00000009, 32'h0,        32'h0, 1'b0, 1'b0, 32'h00000075};
    tbl[9]  = '{6'd0,  32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hCBF43926};
    tbl[10] = '{6'd8,  32'hABCDEF07, 32'h12345600, 32'hFFFFFF00, 1'b0, 1'b0, 32'h000000F4};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_crc", 64'(out_crc), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset-default CRC-32 with busy/cfg_ready probes inside the message.
    load_str("123456789");
    send(1'b0, {24'd0, msg[0]}, 1'b0, 1'b0);
    chk("shift_busy_inready", 64'({busy, in_ready, cfg_ready}), 64'(3'b100));
    repeat (8) @(negedge clk);
    chk("gap_busy_inready", 64'({busy, in_ready, cfg_ready}), 64'(3'b110));
    for (int k = 1; k < 9; k++) send(1'b0, {24'd0, msg[k]}, k == 8, 1'b0);
    get_result(1'b0, 32'hCBF43926, 9, 0, "crc32_default");

    for (int i = 0; i < 11; i++) begin
      do_cfg(tbl[i]);
      send_msg(1'b0, 0, 1'b0);
      get_result(1'b0, tbl[i].exp, 9, 0, $sformatf("table%0d", i));
    end

    // in_valid with flush marks the beat as last.
    do_cfg(crc32);
    for (int k = 0; k < 9; k++) send(1'b0, {24'd0, msg[k]}, 1'b0, k == 8);
    get_result(1'b0, 32'hCBF43926, 9, 0, "beat_with_flush");

    load_str("12345678");
    send_msg(1'b0, 0, 1'b1);
    get_result(1'b0, ref_crc(32, 32'h04C11DB7, '1, '1, 1'b1, 1'b1, msg, 8), 1, 0, "flush_ended");

    // Empty message held in DONE for 20 cycles.
    do_flush();
    chk("empty_valid_latency", 64'(out_valid), 64'(1));
    chk("empty_crc", 64'(out_crc), 64'(0));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!out_valid || out_crc != 32'h0 || in_ready || cfg_ready) bad++;
      @(negedge clk);
    end
    chk("done_hold_stable", 64'(bad), 64'(0));
    get_result(1'b0, 32'h0, 0, 0, "empty_release");

    // u1: 4-beat message, config pending from the second beat until the result is taken.
    load_str("ABCDEFGHIJKLMNOP");
    e = ref_crc(32, 32'h04C11DB7, '1, '1, 1'b1, 1'b1, msg, 16);
    send(1'b1, {msg[3], msg[2], msg[1], msg[0]}, 1'b0, 1'b0);
    cfg_width = 6'd0; cfg_poly = 32'h04C11DB7; cfg_init = '1; cfg_xor = '1;
    cfg_refin = 1'b1; cfg_refout = 1'b1;
    v_cfg_valid = 1'b1;
    mon_en = 1'b1;
    for (int b = 1; b < 4; b++)
      send(1'b1, {msg[4*b+3], msg[4*b+2], msg[4*b+1], msg[4*b]}, b == 3, 1'b0);
    get_result(1'b1, e, 5, 3, "wide_ascii16");
    chk("cfg_stall", 64'(stall_bad), 64'(0));
    chk("cfg_ready_after_result", 64'(v_cfg_ready), 64'(1));
    @(negedge clk);
    v_cfg_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mlen = 4 * $urandom_range(1, 4);
      for (int k = 0; k < mlen; k++) msg[k] = 8'($urandom);
      send_msg(1'b1, 3, 1'b0);
      get_result(1'b1, ref_crc(32, 32'h04C11DB7, '1, '1, 1'b1, 1'b1, msg, mlen),
                 0, $urandom_range(0, 3), $sformatf("wide_rand%0d", i));
    end

    // Reset mid-shift of a final beat: no result, config back to CRC-32.
    do_cfg(tbl[0]);
    load_str("12345");
    send_msg(1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) bad++;
      @(negedge clk);
    end
    chk("abort_no_result", 64'(bad), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    load_str("123456789");
    send_msg(1'b0, 0, 1'b0);
    get_result(1'b0, 32'hCBF43926, 9, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      rv.w = 6'($urandom_range(0, 32));
      rv.poly = $urandom; rv.init = $urandom; rv.xr = $urandom;
      rv.rin = 1'($urandom); rv.rout = 1'($urandom);
      rv.exp = '0;
      do_cfg(rv);
      mlen = $urandom_range(1, 8);
      for (int k = 0; k < mlen; k++) msg[k] = 8'($urandom);
      send_msg(1'b0, 3, $urandom_range(0, 3) == 0);
      get_result(1'b0, ref_crc(int'(rv.w), rv.poly, rv.init, rv.xr, rv.rin, rv.rout, msg, mlen),
                 0, $urandom_range(0, 3), $sformatf("rand%0d_w%0d", i, rv.w));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
